img_readout_formatter: RTL and testbench

Streaming stage directly downstream of the image controller's readout port. On each start toggle it emits a framed image on a ready/trigger output: fixed header words, then pixel words pulled from the RAM readout stream, full-resolution or thumbnail-decimated, then a Fletcher-32 trailer. It drives the upstream `readout_trigger` and feeds the host-facing output FIFO.

---
 rtl/img_readout_formatter_pkg.sv | 28 ++
 rtl/img_readout_formatter_fletcher32.sv | 52 +++++
 rtl/img_readout_formatter.sv | 197 +++++++++++++++++++
 tb/tb_img_readout_formatter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_readout_formatter_pkg.sv
// Shared definitions for the image readout formatter: state encodings,
// the Fletcher-32 modulus and frame-length helpers.
package img_readout_formatter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PIXELS  = 2'd2;
    localparam logic [1:0] ST_TRAILER = 2'd3;

    localparam logic [16:0] FLETCHER_MOD = 17'd65535;

    // Emitted words per frame; trailer adds 2 words when the checksum is built in.
    function automatic int unsigned frame_words_full(input int unsigned width,
                                                     input int unsigned height,
                                                     input int unsigned hdr_words,
                                                     input bit          cks_en);
        return hdr_words + width * height + (cks_en ? 2 : 0);
    endfunction

    function automatic int unsigned frame_words_thumb(input int unsigned width,
                                                      input int unsigned height,
                                                      input int unsigned div,
                                                      input int unsigned hdr_words,
                                                      input bit          cks_en);
        return hdr_words + (width / div) * (height / div) + (cks_en ? 2 : 0);
    endfunction

endpackage

// File: rtl/img_readout_formatter_fletcher32.sv
// img_fletcher32: running Fletcher-32 accumulator, sum = {B, A}; clear beats en.
module img_fletcher32
    import img_readout_formatter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  logic        clear,
    input  logic        en,
    input  logic [15:0] din,
    output logic [31:0] sum
);

    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [16:0] a_sum;
    logic [16:0] b_sum;

    always_comb begin
        a_sum = {1'b0, a_q} + {1'b0, din};
        if (a_sum >= FLETCHER_MOD) begin
            a_sum = a_sum - FLETCHER_MOD;
        end
        // B accumulates the already-updated A
        b_sum = {1'b0, b_q} + a_sum;
        if (b_sum >= FLETCHER_MOD) begin
            b_sum = b_sum - FLETCHER_MOD;
        end

        a_d = a_q;
        b_d = b_q;
        if (clear) begin
            a_d = '0;
            b_d = '0;
        end else if (en) begin
            a_d = a_sum[15:0];
            b_d = b_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign sum = {b_q, a_q};

endmodule

// File: rtl/img_readout_formatter.sv
// img_readout_formatter: frames the image-RAM readout stream as header, pixels and trailer.
// Define IMG_READOUT_FORMATTER_CHECKSUM_EN to build the Fletcher-32 trailer (B then A).
module img_readout_formatter
    import img_readout_formatter_pkg::*;
#(
    parameter int ImgWidth        = 2304,
    parameter int ImgHeight       = 1296,
    parameter int ThumbDiv        = 8,
    parameter int HeaderWordCount = 8
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic                          start,
    input  logic [HeaderWordCount*16-1:0] header,
    input  logic                          thumb,
    input  logic                          src_ready,
    output logic                          src_trigger,
    input  logic [15:0]                   src_data,
    output logic                          out_ready,
    input  logic                          out_trigger,
    output logic [15:0]                   out_data,
    output logic                          done
);

    localparam int HDR_W = HeaderWordCount * 16;
    localparam int XW    = (ImgWidth > 1) ? $clog2(ImgWidth) : 1;
    localparam int YW    = (ImgHeight > 1) ? $clog2(ImgHeight) : 1;
    localparam int WW    = (HeaderWordCount > 2) ? $clog2(HeaderWordCount) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(ImgWidth - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(ImgHeight - 1);
    localparam logic [XW-1:0] X_MASK   = XW'(ThumbDiv - 1);
    localparam logic [YW-1:0] Y_MASK   = YW'(ThumbDiv - 1);
    localparam logic [WW-1:0] HDR_LAST = WW'(HeaderWordCount - 1);

    logic [1:0]       state_q, state_d;
    logic             start_q;
    logic [HDR_W-1:0] header_q, header_d;
    logic             thumb_q, thumb_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic             drain_q, drain_d;
    logic             valid_q, valid_d;
    logic [15:0]      data_q, data_d;
    logic             done_q, done_d;

    logic start_edge;
    logic load_ok;
    logic keep;
    logic frame_end;

    assign start_edge = start ^ start_q;
    assign load_ok    = !valid_q || out_trigger;
    assign keep       = !thumb_q || (((x_q & X_MASK) == '0) && ((y_q & Y_MASK) == '0));
    assign frame_end  = (x_q == X_LAST) && (y_q == Y_LAST);

    assign src_trigger = (state_q == ST_PIXELS) && !drain_q && src_ready
                         && (!keep || load_ok);

`ifdef IMG_READOUT_FORMATTER_CHECKSUM_EN
    logic        cks_en;
    logic [31:0] cks_sum;

    // Header and kept pixel words are accumulated as they enter the output register
    assign cks_en = !start_edge && !drain_q
                    && (((state_q == ST_HEADER) && load_ok)
                        || ((state_q == ST_PIXELS) && src_trigger && keep));

    img_fletcher32 u_fletcher (
        .clk   (clk),
        .rst_  (rst_),
        .clear (start_edge),
        .en    (cks_en),
        .din   (data_d),
        .sum   (cks_sum)
    );
`endif

    always_comb begin
        state_d  = state_q;
        header_d = header_q;
        thumb_d  = thumb_q;
        x_d      = x_q;
        y_d      = y_q;
        wcnt_d   = wcnt_q;
        drain_d  = drain_q;
        valid_d  = valid_q;
        data_d   = data_q;
        done_d   = done_q;

        if (valid_q && out_trigger) begin
            valid_d = 1'b0;
        end

        if (start_edge) begin
            state_d  = ST_HEADER;
            header_d = header;
            thumb_d  = thumb;
            x_d      = '0;
            y_d      = '0;
            wcnt_d   = '0;
            drain_d  = 1'b0;
            valid_d  = 1'b0;
        end else if (drain_q) begin
            // Final word sits in the output register; finish once it is taken
            if (load_ok) begin
                done_d  = !done_q;
                valid_d = 1'b0;
                drain_d = 1'b0;
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_HEADER: begin
                    if (load_ok) begin
                        valid_d  = 1'b1;
                        data_d   = header_q[HDR_W-1 -: 16];
                        header_d = header_q << 16;
                        wcnt_d   = wcnt_q + WW'(1);
                        if (wcnt_q == HDR_LAST) begin
                            wcnt_d  = '0;
                            state_d = ST_PIXELS;
                        end
                    end
                end
                ST_PIXELS: begin
                    if (src_trigger) begin
                        if (keep) begin
                            valid_d = 1'b1;
                            data_d  = src_data;
                        end
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                        if (frame_end) begin
`ifdef IMG_READOUT_FORMATTER_CHECKSUM_EN
                            state_d = ST_TRAILER;
`else
                            drain_d = 1'b1;
`endif
                        end
                    end
                end
`ifdef IMG_READOUT_FORMATTER_CHECKSUM_EN
                ST_TRAILER: begin
                    if (load_ok) begin
                        valid_d = 1'b1;
                        data_d  = (wcnt_q == '0) ? cks_sum[31:16] : cks_sum[15:0];
                        wcnt_d  = wcnt_q + WW'(1);
                        if (wcnt_q != '0) begin
                            drain_d = 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            header_q <= '0;
            thumb_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            wcnt_q   <= '0;
            drain_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            header_q <= header_d;
            thumb_q  <= thumb_d;
            x_q      <= x_d;
            y_q      <= y_d;
            wcnt_q   <= wcnt_d;
            drain_q  <= drain_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign out_ready = valid_q;
    assign out_data  = data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_img_readout_formatter.sv
// Scoreboard bench for img_readout_formatter on a 4x4 image, 2 header words, thumb factor 2.
module tb_img_readout_formatter;
    import img_readout_formatter_pkg::*;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int D   = 2;
    localparam int HWC = 2;
`ifdef IMG_READOUT_FORMATTER_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_;
    logic                start;
    logic [HWC*16-1:0]   header;
    logic                thumb;
    logic                src_ready;
    logic                src_trigger;
    logic [15:0]         src_data;
    logic                out_ready;
    logic                out_trigger;
    logic [15:0]         out_data;
    logic                done;

    int unsigned pass_cnt  = 0;
    int unsigned fail_cnt  = 0;
    int unsigned total_cnt = 0;

    logic [15:0] exp_q[$];
    int unsigned pix;
    int unsigned done_toggles;
    logic        done_prev;
    bit          cur_thumb;

    always #5 clk = ~clk;

    img_readout_formatter #(
        .ImgWidth        (W),
        .ImgHeight       (H),
        .ThumbDiv        (D),
        .HeaderWordCount (HWC)
    ) dut (
        .clk         (clk),
        .rst_        (rst_),
        .start       (start),
        .header      (header),
        .thumb       (thumb),
        .src_ready   (src_ready),
        .src_trigger (src_trigger),
        .src_data    (src_data),
        .out_ready   (out_ready),
        .out_trigger (out_trigger),
        .out_data    (out_data),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference Fletcher-32 using plain modulo arithmetic
    function automatic logic [31:0] fletcher(input logic [15:0] words[$]);
        int unsigned a = 0;
        int unsigned b = 0;
        logic [31:0] r;
        foreach (words[i]) begin
            a = (a + 32'(words[i])) % 65535;
            b = (b + a) % 65535;
        end
        r = {b[15:0], a[15:0]};
        return r;
    endfunction

    task automatic push_frame(input bit tm);
        logic [15:0] words[$];
        logic [31:0] ck;
        words.push_back(16'hAAAA);
        words.push_back(16'h5555);
        for (int unsigned y = 0; y < H; y++) begin
            for (int unsigned x = 0; x < W; x++) begin
                if (!tm || ((x % D == 0) && (y % D == 0))) begin
                    words.push_back(16'(y * W + x));
                end
            end
        end
        if (CKS) begin
            ck = fletcher(words);
            words.push_back(ck[31:16]);
            words.push_back(ck[15:0]);
        end
        foreach (words[i]) exp_q.push_back(words[i]);
    endtask

    // One clock: drive inputs, sample at negedge, account for transfers after the edge
    task automatic step(input bit stress, output bit consumed, output logic [15:0] word);
        bit          src_took;
        logic        done_b;
        logic [31:0] exp;
        src_ready   = stress ? 1'($urandom_range(0, 1)) : 1'b1;
        out_trigger = stress ? 1'($urandom_range(0, 1)) : 1'b1;
        src_data    = 16'(pix);
        @(negedge clk);
        consumed = out_ready && out_trigger;
        word     = out_data;
        src_took = src_ready && src_trigger;
        done_b   = done;
        @(posedge clk);
        #1;
        if (src_took) pix++;
        if (consumed) begin
            exp = (exp_q.size() != 0) ? {16'h0, exp_q.pop_front()} : 32'hDEAD_0000;
            check("out_word", {16'h0, word}, exp);
            if (exp_q.size() == 0 && (CKS || !cur_thumb)) begin
                check("done_at_last", {31'h0, done}, {31'h0, !done_b});
            end
        end
        if (done !== done_prev) begin
            done_toggles++;
            done_prev = done;
        end
    endtask

    // mode 0: plain frame, 1: abort after pixel 5, 2: reset after pixel 5
    task automatic run_frame(input bit tm, input bit stress, input int mode);
        bit          c;
        logic [15:0] w;
        bit          hit = 1'b0;
        int unsigned cyc = 0;
        thumb        = tm;
        cur_thumb    = tm;
        header       = 32'hAAAA_5555;
        pix          = 0;
        done_toggles = 0;
        done_prev    = done;
        push_frame(tm);
        src_ready   = 1'b1;
        out_trigger = 1'b0;
        start       = ~start;
        @(posedge clk); #1;
        check("start_edge_n_ready", {31'h0, out_ready}, 32'h0);
        @(posedge clk); #1;
        check("start_edge_n1_ready", {31'h0, out_ready}, 32'h1);
        check("start_edge_n1_data", {16'h0, out_data}, 32'hAAAA);
        while (!(exp_q.size() == 0 && done_toggles != 0) && cyc < 3000) begin
            step(stress, c, w);
            cyc++;
            if (mode != 0 && !hit && c && w == 16'd5) begin
                hit = 1'b1;
                if (mode == 1) begin
                    exp_q.delete();
                    push_frame(tm);
                    src_ready   = 1'b0;
                    out_trigger = 1'b0;
                    start       = ~start;
                    pix         = 0;
                    @(posedge clk); #1;
                    check("abort_ready_clear", {31'h0, out_ready}, 32'h0);
                end else begin
                    #2;
                    rst_ = 1'b0;
                    #1;
                    check("rst_out_ready", {31'h0, out_ready}, 32'h0);
                    check("rst_out_data", {16'h0, out_data}, 32'h0);
                    check("rst_src_trigger", {31'h0, src_trigger}, 32'h0);
                    check("rst_done", {31'h0, done}, 32'h0);
                    start     = 1'b0;
                    done_prev = 1'b0;
                    exp_q.delete();
                    @(posedge clk); #1;
                    check("rst_hold_ready", {31'h0, out_ready}, 32'h0);
                    #3;
                    rst_ = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        @(posedge clk); #1;
                        check("post_rst_idle_trig", {31'h0, src_trigger}, 32'h0);
                        check("post_rst_idle_ready", {31'h0, out_ready}, 32'h0);
                    end
                    return;
                end
            end
        end
        check("frame_complete", exp_q.size(), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, c, w);
        end
        check("done_toggles", done_toggles, 32'h1);
        check("src_consumed", pix, 32'(W * H));
        check("idle_out_ready", {31'h0, out_ready}, 32'h0);
    endtask

    initial begin
        rst_        = 1'b0;
        start       = 1'b0;
        thumb       = 1'b0;
        header      = 32'hAAAA_5555;
        src_ready   = 1'b0;
        out_trigger = 1'b0;
        src_data    = 16'h0;
        cur_thumb   = 1'b0;
        #12;
        check("reset_out_ready", {31'h0, out_ready}, 32'h0);
        check("reset_out_data", {16'h0, out_data}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_src_trigger", {31'h0, src_trigger}, 32'h0);
        #10;
        rst_ = 1'b1;
        @(posedge clk); #1;

        run_frame(1'b0, 1'b0, 0);
        run_frame(1'b1, 1'b0, 0);
        run_frame(1'b0, 1'b1, 0);
        run_frame(1'b1, 1'b1, 0);
        run_frame(1'b0, 1'b0, 1);
        run_frame(1'b0, 1'b0, 2);
        run_frame(1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
